fir_filter_block: RTL and testbench

- Parametrised block-FIR engine, successor to the fixed 16-bit/8-tap-per-word filter.
- Consumes BLOCK_SIZE signed samples per startIn and produces BLOCK_SIZE saturated outputs y[n] = sum_{j=0..TAPS-1} h[j]*x[n-j].
- Performs MACS multiplies per cycle per lane and keeps sample history across blocks.
- Coefficients are run-time writable and sit beside the audio pipeline in place of the ROM-based filter.

---
 rtl/fir_filter_block.sv | 214 +++++++++++++++++++++
 tb/tb_fir_filter_block.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_filter_block.sv
// fir_filter_block: block FIR engine, BLOCK_SIZE lanes x MACS taps per cycle, run-time writable coefficients.
// Latency: doneOut rises TAPS/MACS+3 edges after the edge that accepts startIn; one block per TAPS/MACS+4 cycles.
// Backpressure: none; startIn is only sampled while idle, and coefficient writes while busy are dropped and flagged.
//
// Ports:
//   clkIn, resetIn             clock, asynchronous active-high reset
//   startIn, dataIn            start request and input block (lane 0 = oldest sample)
//   coefWrIn/AddrIn/DataIn     coefficient write port (h[coefAddrIn] <= coefDataIn when idle)
//   busyOut, doneOut           block in flight; one-cycle pulse when dataOut updates
//   coefErrOut                 one-cycle pulse after a write attempted while busy
//   dataOut                    shifted, saturated results; lane k matches dataIn lane k
// Optional build macro FIR_FILTER_BLOCK_ROUND_EN: round-half-up before the output shift
// (default: truncating arithmetic shift).

module fir_filter_block #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int COEF_WIDTH   = 16,
    parameter int OUT_WIDTH    = 32,
    parameter int TAPS         = 32,
    parameter int MACS         = 8,
    parameter int BLOCK_SIZE   = 4,
    parameter int OUT_SHIFT    = 0
) (
    input  logic                               clkIn,
    input  logic                               resetIn,
    input  logic                               startIn,
    input  logic [SAMPLE_WIDTH*BLOCK_SIZE-1:0] dataIn,
    input  logic                               coefWrIn,
    input  logic [$clog2(TAPS)-1:0]            coefAddrIn,
    input  logic [COEF_WIDTH-1:0]              coefDataIn,
    output logic                               busyOut,
    output logic                               doneOut,
    output logic                               coefErrOut,
    output logic [OUT_WIDTH*BLOCK_SIZE-1:0]    dataOut
);

    localparam int NCYC      = TAPS / MACS;
    localparam int CYC_W     = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam int PROD_W    = SAMPLE_WIDTH + COEF_WIDTH;
    localparam int ACC_WIDTH = SAMPLE_WIDTH + COEF_WIDTH + $clog2(TAPS);
    // Window: TAPS-1 history samples (oldest at index 0) followed by the latched block.
    localparam int WIN       = TAPS - 1 + BLOCK_SIZE;
    // One spare bit over the accumulator so the rounding add can never overflow.
    localparam int EW        = ((ACC_WIDTH > OUT_WIDTH) ? ACC_WIDTH : OUT_WIDTH) + 1;

    localparam logic signed [EW-1:0] SAT_MAX = {{(EW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0] SAT_MIN = {{(EW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
`ifdef FIR_FILTER_BLOCK_ROUND_EN
    // Half an output LSB; shifting 1 up then down by one makes OUT_SHIFT=0 a no-op.
    localparam logic signed [EW-1:0] RND = ({{(EW-1){1'b0}}, 1'b1} << OUT_SHIFT) >> 1;
`else
    localparam logic signed [EW-1:0] RND = '0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                   state, state_nx;
    logic [CYC_W-1:0]         cyc, cyc_nx;
    logic                     accept, finish;

    logic signed [SAMPLE_WIDTH-1:0] win     [WIN];
    logic signed [COEF_WIDTH-1:0]   coef    [TAPS];
    logic signed [COEF_WIDTH-1:0]   coef_q  [MACS];
    logic signed [SAMPLE_WIDTH-1:0] samp_q  [BLOCK_SIZE][MACS];
    logic signed [PROD_W-1:0]       prod_q  [BLOCK_SIZE][MACS];
    logic signed [ACC_WIDTH-1:0]    acc     [BLOCK_SIZE];
    logic signed [ACC_WIDTH-1:0]    lane_sum[BLOCK_SIZE];
    logic signed [EW-1:0]           rnd_acc [BLOCK_SIZE];
    logic signed [EW-1:0]           shf_acc [BLOCK_SIZE];
    logic signed [OUT_WIDTH-1:0]    sat_out [BLOCK_SIZE];
    logic                           s1_vld, s2_vld;

    // ---------------- control FSM ----------------
    always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) begin
            state <= S_IDLE;
            cyc   <= '0;
        end else begin
            state <= state_nx;
            cyc   <= cyc_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cyc_nx   = cyc;
        accept   = 1'b0;
        finish   = 1'b0;
        case (state)
            S_IDLE: begin
                if (startIn) begin
                    accept   = 1'b1;
                    state_nx = S_RUN;
                    cyc_nx   = '0;
                end
            end
            S_RUN: begin
                if (cyc == CYC_W'(NCYC - 1)) begin
                    state_nx = S_DRAIN;
                    cyc_nx   = '0;
                end else begin
                    cyc_nx = cyc + CYC_W'(1);
                end
            end
            S_DRAIN: begin
                // Two cycles: one for the multiplier register, one for the accumulate.
                if (cyc == CYC_W'(1)) begin
                    state_nx = S_DONE;
                    cyc_nx   = '0;
                end else begin
                    cyc_nx = cyc + CYC_W'(1);
                end
            end
            default: begin
                finish   = 1'b1;
                state_nx = S_IDLE;
            end
        endcase
    end

    // ---------------- coefficients, window, status ----------------
    always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) begin
            for (int j = 0; j < TAPS; j++) coef[j] <= '0;
            for (int i = 0; i < WIN; i++)  win[i]  <= '0;
            busyOut    <= 1'b0;
            doneOut    <= 1'b0;
            coefErrOut <= 1'b0;
        end else begin
            // busyOut is registered, so a write on the accepting edge still lands.
            if (coefWrIn && !busyOut && (int'(coefAddrIn) < TAPS))
                coef[coefAddrIn] <= coefDataIn;
            coefErrOut <= coefWrIn && busyOut;
            busyOut    <= (state_nx != S_IDLE);
            doneOut    <= finish;
            if (accept) begin
                for (int k = 0; k < BLOCK_SIZE; k++)
                    win[TAPS-1+k] <= dataIn[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
            end else if (finish) begin
                // Slide by one block: the newest TAPS-1 samples become history.
                for (int i = 0; i < TAPS - 1; i++)
                    win[i] <= win[i+BLOCK_SIZE];
            end
        end
    end

    // ---------------- MAC pipeline: read -> multiply -> accumulate ----------------
    always_comb begin
        for (int k = 0; k < BLOCK_SIZE; k++) begin
            lane_sum[k] = '0;
            for (int m = 0; m < MACS; m++)
                lane_sum[k] = lane_sum[k] + ACC_WIDTH'(prod_q[k][m]);
        end
    end

    always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
            for (int m = 0; m < MACS; m++) coef_q[m] <= '0;
            for (int k = 0; k < BLOCK_SIZE; k++) begin
                acc[k] <= '0;
                for (int m = 0; m < MACS; m++) begin
                    samp_q[k][m] <= '0;
                    prod_q[k][m] <= '0;
                end
            end
        end else begin
            s1_vld <= (state == S_RUN);
            s2_vld <= s1_vld;
            if (state == S_RUN) begin
                // Chunk cyc covers taps cyc*MACS .. cyc*MACS+MACS-1; lane k tap j uses win[TAPS-1+k-j].
                for (int m = 0; m < MACS; m++)
                    coef_q[m] <= coef[int'(cyc)*MACS + m];
                for (int k = 0; k < BLOCK_SIZE; k++)
                    for (int m = 0; m < MACS; m++)
                        samp_q[k][m] <= win[TAPS - 1 + k - int'(cyc)*MACS - m];
            end
            for (int k = 0; k < BLOCK_SIZE; k++)
                for (int m = 0; m < MACS; m++)
                    prod_q[k][m] <= PROD_W'(samp_q[k][m]) * PROD_W'(coef_q[m]);
            for (int k = 0; k < BLOCK_SIZE; k++) begin
                if (accept)
                    acc[k] <= '0;
                else if (s2_vld)
                    acc[k] <= acc[k] + lane_sum[k];
            end
        end
    end

    // ---------------- output shaping: round, shift, saturate ----------------
    always_comb begin
        for (int k = 0; k < BLOCK_SIZE; k++) begin
            rnd_acc[k] = EW'(acc[k]) + RND;
            shf_acc[k] = rnd_acc[k] >>> OUT_SHIFT;
            if (shf_acc[k] > SAT_MAX)
                sat_out[k] = SAT_MAX[OUT_WIDTH-1:0];
            else if (shf_acc[k] < SAT_MIN)
                sat_out[k] = SAT_MIN[OUT_WIDTH-1:0];
            else
                sat_out[k] = shf_acc[k][OUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) begin
            dataOut <= '0;
        end else if (finish) begin
            for (int k = 0; k < BLOCK_SIZE; k++)
                dataOut[k*OUT_WIDTH +: OUT_WIDTH] <= sat_out[k];
        end
    end

endmodule

// File: tb/tb_fir_filter_block.sv
// tb_fir_filter_block: directed + randomized checks of fir_filter_block against a convolution model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).

module tb_fir_filter_block;

    localparam int T = 8, M = 4, B = 4, N = T / M;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic         clk, rst;
    logic         start, coef_wr, busy, done, coef_err;
    logic [63:0]  data;
    logic [2:0]   coef_addr;
    logic [15:0]  coef_data;
    logic [127:0] dout;

    logic         start_r, coef_wr_r, busy_r, done_r, coef_err_r;
    logic [63:0]  data_r;
    logic [2:0]   coef_addr_r;
    logic [15:0]  coef_data_r;
    logic [127:0] dout_r;

    int tests = 0;
    int fails = 0;

    longint h_m[T];
    longint stream[$];

    fir_filter_block #(.SAMPLE_WIDTH(16), .COEF_WIDTH(16), .OUT_WIDTH(32), .TAPS(T),
                       .MACS(M), .BLOCK_SIZE(B), .OUT_SHIFT(0)) dut (
        .clkIn(clk), .resetIn(rst), .startIn(start), .dataIn(data),
        .coefWrIn(coef_wr), .coefAddrIn(coef_addr), .coefDataIn(coef_data),
        .busyOut(busy), .doneOut(done), .coefErrOut(coef_err), .dataOut(dout));

    fir_filter_block #(.SAMPLE_WIDTH(16), .COEF_WIDTH(16), .OUT_WIDTH(32), .TAPS(T),
                       .MACS(M), .BLOCK_SIZE(B), .OUT_SHIFT(2)) dut_r (
        .clkIn(clk), .resetIn(rst), .startIn(start_r), .dataIn(data_r),
        .coefWrIn(coef_wr_r), .coefAddrIn(coef_addr_r), .coefDataIn(coef_data_r),
        .busyOut(busy_r), .doneOut(done_r), .coefErrOut(coef_err_r), .dataOut(dout_r));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint floor_div(longint a, longint d);
        if (a >= 0) return a / d;
        return -((-a + d - 1) / d);
    endfunction

    // Divide by 2^sh (floor or round-half-up), then clamp to the 32-bit signed range.
    function automatic longint shape(longint a, int sh);
        longint p = 1;
        longint v;
        for (int i = 0; i < sh; i++) p = p * 2;
`ifdef FIR_FILTER_BLOCK_ROUND_EN
        v = floor_div(a + p / 2, p);
`else
        v = floor_div(a, p);
`endif
        if (v > MAXV) v = MAXV;
        if (v < MINV) v = MINV;
        return v;
    endfunction

    // y[n] = sum h[j]*x[n-j] over the sample stream since the last reset.
    function automatic longint model_lane(int k);
        longint s = 0;
        int n = stream.size() - B + k;
        for (int j = 0; j < T; j++)
            if (n - j >= 0) s += h_m[j] * stream[n - j];
        return s;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_lanes(input string tag);
        longint e;
        for (int k = 0; k < B; k++) begin
            e = shape(model_lane(k), 0);
            chk(tag, 128'(dout[k*32 +: 32]), 128'(e[31:0]));
        end
    endtask

    task automatic push_block(input logic [63:0] blk);
        for (int k = 0; k < B; k++) stream.push_back(longint'($signed(blk[k*16 +: 16])));
    endtask

    task automatic wcoef(input int a, input logic [15:0] v);
        coef_addr = a[2:0];
        coef_data = v;
        coef_wr   = 1'b1;
        @(negedge clk);
        coef_wr   = 1'b0;
        h_m[a]    = longint'($signed(v));
        chk("coef_err_idle", 128'(coef_err), 128'(0));
    endtask

    // wr_cyc: 0 = write h[0]=5 on the accepting edge, >0 = write at that cycle (busy), <0 = none.
    // restart_cyc: >0 = pulse startIn at that cycle while busy.
    task automatic run_block(input logic [63:0] blk, input int wr_cyc, input int restart_cyc);
        int cnt = 0;
        bit got = 1'b0;
        data  = blk;
        start = 1'b1;
        if (wr_cyc == 0) begin
            coef_wr = 1'b1; coef_addr = 3'd0; coef_data = 16'd5;
            h_m[0] = 5;
        end
        push_block(blk);
        while (!got && cnt < 40) begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) begin
                start = 1'b0;
                chk("busy_after_start", 128'(busy), 128'(1));
            end
            if (cnt == wr_cyc + 1) begin
                coef_wr = 1'b0;
                chk("coef_err_pulse", 128'(coef_err), 128'(wr_cyc > 0));
            end
            if (wr_cyc > 0 && cnt == wr_cyc) begin
                coef_wr = 1'b1; coef_addr = 3'd0; coef_data = 16'd5;
            end
            if (wr_cyc > 0 && cnt == wr_cyc + 2)
                chk("coef_err_clear", 128'(coef_err), 128'(0));
            if (restart_cyc > 0 && cnt == restart_cyc) start = 1'b1;
            if (restart_cyc > 0 && cnt == restart_cyc + 1) start = 1'b0;
            got = done;
        end
        chk("done_latency", 128'(cnt - 1), 128'(N + 3));
        chk_lanes("lane_value");
        @(negedge clk);
        chk("done_one_cycle", 128'(done), 128'(0));
        chk("idle_after_done", 128'(busy), 128'(0));
    endtask

    initial begin
        logic [63:0]  d;
        logic [127:0] ex;
        longint       e;
        int           cnt, ndone, last;

        rst = 1'b1; start = 1'b0; coef_wr = 1'b0; data = '0; coef_addr = '0; coef_data = '0;
        start_r = 1'b0; coef_wr_r = 1'b0; data_r = '0; coef_addr_r = '0; coef_data_r = '0;
        for (int j = 0; j < T; j++) h_m[j] = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", 128'(busy), 128'(0));
        chk("reset_done", 128'(done), 128'(0));
        chk("reset_coef_err", 128'(coef_err), 128'(0));
        chk("reset_dout", dout, 128'(0));

        // Impulse through h[j] = j+1, then its tail in the following block.
        for (int j = 0; j < T; j++) wcoef(j, 16'(j + 1));
        run_block(64'h0000_0000_0000_0001, -1, -1);
        chk("impulse_first", dout, {32'd4, 32'd3, 32'd2, 32'd1});
        run_block(64'h0, -1, -1);
        chk("impulse_tail", dout, {32'd8, 32'd7, 32'd6, 32'd5});
        run_block(64'h0, -1, -1);
        chk("impulse_gone", dout, 128'(0));

        // Write while busy is dropped; write on the accepting edge is used.
        run_block(64'h0, 2, -1);
        run_block(64'h0000_0000_0000_0001, 0, -1);
        chk("h0_written_on_start", 128'(dout[31:0]), 128'(5));

        // Start pulse during RUN is ignored.
        run_block({$urandom, $urandom}, -1, 2);

        // Saturation at both rails.
        for (int j = 0; j < T; j++) wcoef(j, 16'h7FFF);
        repeat (3) run_block({4{16'h7FFF}}, -1, -1);
        chk("sat_pos", dout, {4{32'h7FFF_FFFF}});
        repeat (3) run_block({4{16'h8000}}, -1, -1);
        chk("sat_neg", dout, {4{32'h8000_0000}});

        // Random coefficients and blocks.
        for (int j = 0; j < T; j++) wcoef(j, 16'($urandom));
        for (int b = 0; b < 6; b++) run_block({$urandom, $urandom}, -1, -1);

        // startIn held high for 20 edges: blocks every N+4 cycles.
        d = {$urandom, $urandom};
        data = d; start = 1'b1; ndone = 0; last = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 20) start = 1'b0;
            if (done) begin
                ndone++;
                push_block(d);
                chk("held_spacing", 128'(i - last), 128'(N + 4));
                chk_lanes("held_lane");
                last = i;
            end
        end
        chk("held_done_count", 128'(ndone), 128'(4));
        chk("held_idle", 128'(busy), 128'(0));

        // Reset in the middle of RUN.
        data = {$urandom, $urandom}; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 128'(busy), 128'(0));
        chk("midrst_done", 128'(done), 128'(0));
        chk("midrst_dout", dout, 128'(0));
        stream.delete();
        for (int j = 0; j < T; j++) h_m[j] = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_block(64'h0000_0000_0000_0001, -1, -1);
        chk("coefs_cleared", dout, 128'(0));
        run_block(64'h0, -1, -1);
        for (int j = 0; j < T; j++) wcoef(j, 16'(j + 1));
        run_block(64'h0000_0000_0000_0001, -1, -1);
        chk("impulse_after_rewrite", dout, {32'd4, 32'd3, 32'd2, 32'd1});

        // Rounding/truncation on the OUT_SHIFT=2 instance with h[0]=1 only.
        coef_addr_r = 3'd0; coef_data_r = 16'd1; coef_wr_r = 1'b1;
        @(negedge clk);
        coef_wr_r = 1'b0;
        for (int p = 0; p < 2; p++) begin
            d = (p == 0) ? 64'h0000_0000_0000_0006 : 64'h0000_0000_0000_FFFA;
            data_r = d; start_r = 1'b1;
            cnt = 0;
            while (!done_r && cnt < 40) begin
                @(negedge clk);
                start_r = 1'b0;
                cnt++;
            end
            chk("round_latency", 128'(cnt - 1), 128'(N + 3));
            ex = '0;
            for (int k = 0; k < B; k++) begin
                e = shape(longint'($signed(d[k*16 +: 16])), 2);
                ex[k*32 +: 32] = e[31:0];
            end
            chk((p == 0) ? "round_pos6" : "round_neg6", dout_r, ex);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
